// File: rtl/core_if_fetch.sv
// Purpose : instruction-fetch stage of the 64-bit MIPS pipeline. It owns the fetch PC,
//           runs a single-outstanding req/valid handshake with instruction memory, and
//           registers {inst, pc, pc4} into IF_regs for decode.
// Latency : a response accepted at a clock edge is in IF_regs after that edge. Memory with
//           zero latency gives one instruction per cycle with no bubbles.
// Backpr. : a stall holds IF_regs. A response that arrives during a stall is parked in a
//           one-entry skid buffer, and imem_req drops until decode takes that entry.
//
// Ports:
//   clock, reset              clock; asynchronous active-high reset
//   stall                     decode/hazard stall, IF_regs holds
//   flush                     squash the instruction entering decode (IF_regs <= '0)
//   redirect_valid/_pc        new fetch target (low two bits ignored)
//   imem_req/imem_addr        fetch request, held with a stable address until imem_valid
//   imem_rdata/imem_valid     response word and strobe (same-cycle response allowed)
//   IF_regs                   {inst, pc, pc4} to decode
//   imem_wait                 decode got a bubble because memory had no data

package core_if_fetch_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] pc4;
  } IF_regs_t;

endpackage

module core_if_fetch
  import core_if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output IF_regs_t    IF_regs,
  output logic        imem_wait
);

  // RUN  : a request for fetch_pc is outstanding.
  // HOLD : a response is parked in the skid buffer. No request is issued.
  // DROP : a request for a stale address (stale_addr) is still outstanding.
  //        Its response is thrown away.
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_q,      state_d;
  logic [63:0] fetch_pc_q,   fetch_pc_d;
  logic [63:0] stale_addr_q, stale_addr_d;
  logic [31:0] skid_inst_q,  skid_inst_d;
  logic [63:0] skid_pc_q,    skid_pc_d;
  IF_regs_t    if_regs_q,    if_regs_d;
  logic        imem_wait_q,  imem_wait_d;

  logic [63:0] redirect_tgt;
  logic [63:0] fetch_pc_inc;
  logic [63:0] skid_pc_inc;
  IF_regs_t    bubble;
  logic        take;
  logic        unused_redirect_lo;

  // Targets are word aligned. The low two bits of redirect_pc are discarded.
  assign redirect_tgt       = {redirect_pc[63:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Both adders wrap modulo 2^64.
  assign fetch_pc_inc = fetch_pc_q + 64'd4;
  assign skid_pc_inc  = skid_pc_q + 64'd4;

  // Bubbles leave pc and pc4 at zero. Only the instruction word is the NOP encoding.
  assign bubble = {NOP_INST, 64'd0, 64'd0};

  // Decode can take a new instruction into IF_regs this cycle.
  assign take = !stall && !flush;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if_regs_d    = if_regs_q;
    imem_wait_d  = 1'b0;

    if (redirect_valid) begin
      // A redirect always retargets fetch. Leaving HOLD empties the skid buffer.
      fetch_pc_d = redirect_tgt;
      case (state_q)
        ST_RUN: begin
          // If no response arrived this cycle, the old request stays outstanding.
          // Keep its address on the bus until memory answers it.
          if (!imem_valid) begin
            state_d      = ST_DROP;
            stale_addr_d = fetch_pc_q;
          end
        end
        ST_HOLD: state_d = ST_RUN;
        ST_DROP: begin
          // If the stale response lands in the same cycle, nothing is left outstanding.
          // Fetch can then start at the new target at once.
          if (imem_valid) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
      // The stage that redirects also asserts flush when the held instruction must die.
      if (flush) begin
        if_regs_d = '0;
      end else if (!stall) begin
        if_regs_d = bubble;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (imem_valid) begin
            fetch_pc_d = fetch_pc_inc;
            if (take) begin
              if_regs_d = {imem_rdata, fetch_pc_q, fetch_pc_inc};
            end else begin
              // Decode cannot take the word, because of a stall or a flush.
              // It is still the correct next instruction, so park it.
              skid_inst_d = imem_rdata;
              skid_pc_d   = fetch_pc_q;
              state_d     = ST_HOLD;
            end
          end else if (take) begin
            if_regs_d   = bubble;
            imem_wait_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (take) begin
            if_regs_d = {skid_inst_q, skid_pc_q, skid_pc_inc};
            state_d   = ST_RUN;
          end
        end
        ST_DROP: begin
          // fetch_pc already holds the redirect target. Only the stale beat is awaited.
          if (imem_valid) begin
            state_d = ST_RUN;
          end
          if (take) begin
            if_regs_d   = bubble;
            imem_wait_d = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
      // A flush overrides a stall and clears whatever decode is about to see.
      if (flush) begin
        if_regs_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= '0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      if_regs_q    <= {NOP_INST, 64'd0, 64'd0};
      imem_wait_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      if_regs_q    <= if_regs_d;
      imem_wait_q  <= imem_wait_d;
    end
  end

  // The request is a pure function of state. It drops only while a response is parked.
  assign imem_req  = (state_q == ST_RUN) || (state_q == ST_DROP);
  assign imem_addr = (state_q == ST_DROP) ? stale_addr_q : fetch_pc_q;
  assign IF_regs   = if_regs_q;
  assign imem_wait = imem_wait_q;

endmodule
